// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one 8N1 UART transmit line between N requesters. A round-robin
// arbiter picks one pending requester at each arbitration point (any idle
// cycle, or the last cycle of a stop bit). The winner's byte is latched and
// acknowledged with a one-cycle pulse. The byte is then sent as a start bit,
// eight data bits LSB first, and a stop bit, each CLKS_PER_BIT cycles long.
//
// Parameters:
//   N             number of requesters (2..16)
//   CLKS_PER_BIT  clk_i cycles per UART bit (>=1)
//
// Ports:
//   clk_i   system clock, rising edge
//   rst_i   asynchronous active-high reset
//   req_i   per-requester request level, held until acknowledged
//   d_i     request data, byte k = d_i[8k+7:8k]
//   ack_o   one-cycle pulse: byte of requester k latched
//   gnt_o   index of the requester owning the current/last frame
//   busy_o  high while a frame is on the line
//   tx_o    registered serial output, idle high
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int N            = 4,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [N-1:0]         req_i,
   input  logic [8*N-1:0]       d_i,
   output logic [N-1:0]         ack_o,
   output logic [$clog2(N)-1:0] gnt_o,
   output logic                 busy_o,
   output logic                 tx_o
);

   localparam int GW = $clog2(N);
   // At one cycle per bit the counter never leaves 0; keep it one bit wide.
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
   localparam logic [GW-1:0] LAST_RST = GW'(N - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q,   cnt_d;
   logic [2:0]      idx_q,   idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [GW-1:0]   gnt_q,   gnt_d;
   logic [GW-1:0]   last_q,  last_d;
   logic [N-1:0]    ack_q,   ack_d;
   logic            tx_q,    tx_d;

   logic [7:0]      d_byte [N];
   logic            cnt_last;
   logic            arb_point;
   logic            grant;
   logic [GW-1:0]   start_idx;
   logic [2*N-1:0]  req_dbl;
   logic [N-1:0]    req_rot;
   logic [GW-1:0]   win_off;
   logic [GW:0]     win_sum;
   logic [GW-1:0]   win_idx;

   // Unpack the per-requester data bytes.
   for (genvar gi = 0; gi < N; gi++) begin : g_bytes
      assign d_byte[gi] = d_i[8*gi +: 8];
   end

   assign cnt_last  = (cnt_q == CNT_MAX);
   assign arb_point = (state_q == IDLE) || ((state_q == STOP) && cnt_last);
   assign grant     = arb_point && (req_i != '0);

   // Round-robin search: rotate the request vector so the requester after
   // the last winner sits at bit 0, take the lowest set bit, rotate back.
   assign start_idx = (last_q == LAST_RST) ? '0 : last_q + 1'b1;
   assign req_dbl   = {req_i, req_i};
   assign req_rot   = req_dbl[start_idx +: N];

   always_comb begin
      win_off = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            win_off = GW'(i);
         end
      end
   end

   assign win_sum = {1'b0, start_idx} + {1'b0, win_off};
   assign win_idx = (win_sum >= (GW+1)'(N)) ? GW'(win_sum - (GW+1)'(N)) : GW'(win_sum);

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         gnt_q   <= '0;
         last_q  <= LAST_RST;
         ack_q   <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         ack_q   <= ack_d;
         tx_q    <= tx_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      gnt_d   = gnt_q;
      last_d  = last_q;

      case (state_q)
         IDLE: begin
            if (grant) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            if (cnt_last) begin
               state_d = DATA;
               cnt_d   = '0;
               idx_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_last) begin
               cnt_d = '0;
               if (idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_last) begin
               cnt_d   = '0;
               // Pending requests chain straight into the next start bit.
               state_d = grant ? START : IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      if (grant) begin
         shift_d = d_byte[win_idx];
         gnt_d   = win_idx;
         last_d  = win_idx;
      end
   end

   // Output logic. The line level is decoded from the next state so that
   // tx_o can be a flop and still change on the same edge as the state.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[idx_d];
         default: tx_d = 1'b1;
      endcase
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_ack
      assign ack_d[gi] = grant && (win_idx == GW'(gi));
   end

   assign ack_o  = ack_q;
   assign gnt_o  = gnt_q;
   assign busy_o = (state_q != IDLE);
   assign tx_o   = tx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

   localparam int N   = 4;
   localparam int CPB = 4;

   logic           clk = 1'b0;
   logic           rst_i = 1'b1;
   logic [N-1:0]   req_i = '0;
   logic [8*N-1:0] d_i = '0;
   logic [N-1:0]   ack_o;
   logic [1:0]     gnt_o;
   logic           busy_o;
   logic           tx_o;

   // Second instance at one clock per bit.
   logic           rst_b = 1'b1;
   logic [N-1:0]   req_b = '0;
   logic [8*N-1:0] d_b = '0;
   logic [N-1:0]   ack_b;
   logic [1:0]     gnt_b;
   logic           busy_b;
   logic           tx_b;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit chk_en   = 1'b0;
   bit ack1_seen = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   uart_tx_arbiter #(.N(N), .CLKS_PER_BIT(CPB)) dut (
      .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .d_i(d_i),
      .ack_o(ack_o), .gnt_o(gnt_o), .busy_o(busy_o), .tx_o(tx_o)
   );

   uart_tx_arbiter #(.N(N), .CLKS_PER_BIT(1)) dut_b (
      .clk_i(clk), .rst_i(rst_b), .req_i(req_b), .d_i(d_b),
      .ack_o(ack_b), .gnt_o(gnt_b), .busy_o(busy_b), .tx_o(tx_b)
   );

   // ---------------- reference model (frame-offset view) ----------------
   // A frame is described by its start offset: pos counts cycles since the
   // start bit began; the line level is a function of pos/CPB.
   int         m_active = 0;
   int         m_pos    = 0;
   int         m_last   = N - 1;
   int         m_gnt    = 0;
   logic [7:0] m_byte   = '0;
   logic [N-1:0] m_ack  = '0;

   function automatic int rr_pick(input logic [N-1:0] r, input int last);
      for (int i = 1; i <= N; i++) begin
         if (r[(last + i) % N]) return (last + i) % N;
      end
      return -1;
   endfunction

   function automatic logic exp_tx();
      int b;
      if (m_active == 0) return 1'b1;
      b = m_pos / CPB;
      if (b == 0) return 1'b0;
      if (b <= 8) return m_byte[b-1];
      return 1'b1;
   endfunction

   always @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         m_active = 0; m_pos = 0; m_last = N - 1; m_gnt = 0; m_ack = '0;
      end else begin
         m_ack = '0;
         if (m_active == 0 || m_pos == 10*CPB - 1) begin
            if (req_i != '0) begin
               int w;
               w        = rr_pick(req_i, m_last);
               m_active = 1;
               m_pos    = 0;
               m_byte   = d_i[8*w +: 8];
               m_gnt    = w;
               m_last   = w;
               m_ack    = 4'(1 << w);
            end else begin
               m_active = 0;
            end
         end else begin
            m_pos++;
         end
      end
   end

   always @(negedge clk) begin
      if (ack_o[1]) ack1_seen = 1'b1;
      if (chk_en) begin
         n_checks++;
         if (tx_o !== exp_tx() || busy_o !== (m_active != 0) ||
             ack_o !== m_ack || gnt_o !== 2'(m_gnt)) begin
            n_fail++;
            $display("FAIL model t=%0d: tx=%b busy=%b ack=%b gnt=%0d required tx=%b busy=%b ack=%b gnt=%0d",
                     cyc, tx_o, busy_o, ack_o, gnt_o, exp_tx(), (m_active != 0), m_ack, m_gnt);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic wait_ack(input int w, input string nm);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (ack_o == '0 && k < 200);
      check_eq(nm, 32'({ack_o, gnt_o, busy_o, tx_o}), 32'({4'(1 << w), 2'(w), 1'b1, 1'b0}));
   endtask

   // Called on the negedge of the first start-bit cycle; samples mid-bit.
   task automatic check_frame(input logic [7:0] exp, input string nm);
      logic [9:0] bits;
      int nb;
      bits = '0;
      nb   = 0;
      for (int p = 0; p < 10*CPB; p++) begin
         if (p > 0) @(negedge clk);
         if (busy_o) nb++;
         if (p % CPB == CPB/2) bits[p/CPB] = tx_o;
      end
      check_eq({nm, "_bits"}, 32'(bits), 32'({1'b1, exp, 1'b0}));
      check_eq({nm, "_busy"}, 32'(nb), 32'(10*CPB));
   endtask

   task automatic set_bytes(input logic [7:0] base);
      for (int k = 0; k < N; k++) d_i[8*k +: 8] = base + 8'(k);
   endtask

   typedef struct {
      logic [N-1:0] req;
      logic [7:0]   base;
      int           exp_w;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int t0, t3, k;
      logic [9:0] bb;
      int nb;

      // Expected winners follow from the round-robin rule and the history
      // (last winner = 0 after the first directed frame).
      vecs[0] = '{4'b0110, 8'h5F, 1};
      vecs[1] = '{4'b0110, 8'hC3, 2};
      vecs[2] = '{4'b1001, 8'h0E, 3};
      vecs[3] = '{4'b1001, 8'h71, 0};
      vecs[4] = '{4'b1111, 8'h96, 1};
      vecs[5] = '{4'b0001, 8'h2B, 0};
      vecs[6] = '{4'b1000, 8'hE4, 3};
      vecs[7] = '{4'b0101, 8'h80, 0};
      vecs[8] = '{4'b0101, 8'h3D, 2};

      // Reset state.
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check_eq("reset_state", 32'({tx_o, busy_o, ack_o, gnt_o}), 32'({1'b1, 1'b0, 4'b0000, 2'd0}));
      #2 rst_i = 1'b0; rst_b = 1'b0;

      // Single frame, byte 0xA5 from requester 0.
      @(negedge clk);
      d_i[7:0] = 8'hA5;
      req_i    = 4'b0001;
      wait_ack(0, "a5_ack");
      req_i = '0;
      check_frame(8'hA5, "a5_frame");
      @(negedge clk);
      check_eq("a5_after", 32'({busy_o, tx_o, ack_o}), 32'({1'b0, 1'b1, 4'b0000}));

      // Table-driven arbitration vectors.
      for (int v = 0; v < 9; v++) begin
         @(negedge clk);
         set_bytes(vecs[v].base);
         req_i = vecs[v].req;
         wait_ack(vecs[v].exp_w, $sformatf("vec%0d_ack", v));
         req_i = '0;
         check_frame(vecs[v].base + 8'(vecs[v].exp_w), $sformatf("vec%0d", v));
         $display("vec %0d: req=%b winner=%0d byte=%02h", v, vecs[v].req, vecs[v].exp_w,
                  vecs[v].base + 8'(vecs[v].exp_w));
      end

      // All four held from reset: order 0,1,2,3, back-to-back frames.
      @(negedge clk);
      #2 rst_i = 1'b1;
      d_i   = {8'h44, 8'h33, 8'h22, 8'h11};
      req_i = 4'b1111;
      @(negedge clk);
      #2 rst_i = 1'b0;
      wait_ack(0, "all_ack0"); t0 = cyc;
      check_frame(8'h11, "all_f0");
      wait_ack(1, "all_ack1");
      check_frame(8'h22, "all_f1");
      wait_ack(2, "all_ack2");
      check_frame(8'h33, "all_f2");
      wait_ack(3, "all_ack3"); t3 = cyc;
      req_i = '0;
      check_frame(8'h44, "all_f3");
      check_eq("all_spacing", 32'(t3 - t0), 32'(30*CPB));

      // Fairness: after a frame for 2, requests 1 and 3 -> 3 then 1.
      @(negedge clk);
      d_i   = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
      req_i = 4'b0100;
      wait_ack(2, "fair_ack2");
      req_i = 4'b1010;
      check_frame(8'hC3, "fair_f2");
      wait_ack(3, "fair_ack3");
      req_i = 4'b0010;
      check_frame(8'hD4, "fair_f3");
      wait_ack(1, "fair_ack1");
      req_i = '0;
      check_frame(8'hB2, "fair_f1");

      // Mid-frame request/data changes have no effect.
      @(negedge clk);
      d_i[7:0] = 8'h3C;
      req_i    = 4'b0001;
      wait_ack(0, "mid_ack0");
      req_i     = '0;
      ack1_seen = 1'b0;
      fork
         check_frame(8'h3C, "mid_frame");
         begin
            repeat (5) @(negedge clk);
            req_i[1] = 1'b1;
            d_i[7:0] = 8'hFF;
            repeat (10) @(negedge clk);
            req_i[1] = 1'b0;
         end
      join
      repeat (20) @(negedge clk);
      check_eq("mid_no_ack1", 32'(ack1_seen), 32'(0));

      // Reset during data bit 3 of a frame for requester 1.
      @(negedge clk);
      d_i   = {8'h00, 8'hC6, 8'h77, 8'h00};
      req_i = 4'b0010;
      wait_ack(1, "rst_ack1");
      req_i = '0;
      repeat (4*CPB + 1) @(negedge clk);
      #2 rst_i = 1'b1;
      req_i = 4'b0100;
      #1 check_eq("rst_async", 32'({tx_o, busy_o, ack_o, gnt_o}), 32'({1'b1, 1'b0, 4'b0000, 2'd0}));
      @(negedge clk);
      #2 rst_i = 1'b0;
      wait_ack(2, "rst_ack2");
      req_i = '0;
      check_frame(8'hC6, "rst_f2");

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         for (int q = 0; q < N; q++) begin
            if (ack_o[q]) begin
               req_i[q] = 1'($urandom_range(0, 1));
               d_i[8*q +: 8] = 8'($urandom);
            end else if (req_i[q]) begin
               if ($urandom_range(0, 15) == 0) req_i[q] = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
               req_i[q] = 1'b1;
               d_i[8*q +: 8] = 8'($urandom);
            end
         end
      end
      req_i = '0;
      repeat (12*CPB) @(negedge clk);
      check_eq("rand_idle", 32'({busy_o, tx_o}), 32'({1'b0, 1'b1}));
      $display("random phase done at cycle %0d", cyc);

      // One clock per bit, byte 0x00: 9 low cycles then 1 high.
      @(negedge clk);
      d_b   = '0;
      req_b = 4'b0001;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (ack_b == '0 && k < 20);
      check_eq("cpb1_ack", 32'({ack_b, gnt_b}), 32'({4'b0001, 2'd0}));
      req_b = '0;
      bb = '0;
      nb = 0;
      for (int p = 0; p < 10; p++) begin
         if (p > 0) @(negedge clk);
         bb[p] = tx_b;
         if (busy_b) nb++;
      end
      check_eq("cpb1_bits", 32'(bb), 32'(10'b1000000000));
      check_eq("cpb1_busy", 32'(nb), 32'(10));
      @(negedge clk);
      check_eq("cpb1_after", 32'({busy_b, tx_b}), 32'({1'b0, 1'b1}));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
